// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: computes the real next PC, issues a registered
// redirect on mispredict, produces the JAL/JALR link value and flags misaligned targets.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [1:0]           i_op,
  input  logic                 i_cond,
  input  logic                 i_pred_taken,
  input  logic [XLEN-1:0]      i_pc,
  input  logic [XLEN-1:0]      i_imm,
  input  logic [XLEN-1:0]      i_rs1,
  output logic                 o_link_valid,
  output logic [XLEN-1:0]      o_link,
  output logic                 o_redirect_valid,
  input  logic                 i_redirect_ready,
  output logic [XLEN-1:0]      o_redirect_pc,
  output logic                 o_flush,
  output logic                 o_misaligned,
  output logic [XLEN-1:0]      o_bad_addr,
  output logic [CNT_WIDTH-1:0] o_mispredict_count
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_JAL  = 2'b10;
  localparam logic [1:0] OP_JALR = 2'b11;

  localparam logic [XLEN-1:0]      PC_STEP = XLEN'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state;

  logic            accept_p0;
  logic            taken_p0;
  logic            is_jump_p0;
  logic            misaligned_p0;
  logic            mispredict_p0;
  logic [XLEN-1:0] seq_pc_p0;
  logic [XLEN-1:0] br_tgt_p0;
  logic [XLEN-1:0] target_p0;
  logic [XLEN-1:0] actual_p0;
  logic [XLEN-1:0] pred_p0;

  // JALR clears bit 0 of the base+offset sum; everything else is pc-relative.
  function automatic logic [XLEN-1:0] jump_target(input logic [1:0]      op,
                                                  input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] rs1,
                                                  input logic [XLEN-1:0] imm);
    logic [XLEN-1:0] sum;
    if (op == OP_JALR) begin
      sum = rs1 + imm;
      return {sum[XLEN-1:1], 1'b0};
    end
    return pc + imm;
  endfunction

  // Stage p0: combinational resolution of the instruction presented this cycle
  always_comb begin
    accept_p0  = i_valid && o_ready;
    seq_pc_p0  = i_pc + PC_STEP;
    br_tgt_p0  = i_pc + i_imm;
    target_p0  = jump_target(i_op, i_pc, i_rs1, i_imm);
    is_jump_p0 = i_op[1];

    case (i_op)
      OP_BR:   taken_p0 = i_cond;
      OP_JAL,
      OP_JALR: taken_p0 = 1'b1;
      default: taken_p0 = 1'b0;
    endcase

    actual_p0 = taken_p0 ? target_p0 : seq_pc_p0;

    // Decode already steers JAL to its target; JALR and non-branches fall through.
    case (i_op)
      OP_BR:   pred_p0 = i_pred_taken ? br_tgt_p0 : seq_pc_p0;
      OP_JAL:  pred_p0 = target_p0;
      default: pred_p0 = seq_pc_p0;
    endcase

    misaligned_p0 = taken_p0 && (target_p0[1:0] != 2'b00);
    mispredict_p0 = !misaligned_p0 && (actual_p0 != pred_p0);
  end

  // Stage p1: registered outputs and redirect handshake state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      o_ready            <= 1'b1;
      o_redirect_valid   <= 1'b0;
      o_redirect_pc      <= '0;
      o_flush            <= 1'b0;
      o_misaligned       <= 1'b0;
      o_bad_addr         <= '0;
      o_link_valid       <= 1'b0;
      o_link             <= '0;
      o_mispredict_count <= '0;
    end else begin
      o_flush      <= 1'b0;
      o_misaligned <= 1'b0;
      o_link_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept_p0) begin
            if (is_jump_p0) begin
              o_link_valid <= 1'b1;
              o_link       <= seq_pc_p0;
            end
            if (misaligned_p0) begin
              o_misaligned <= 1'b1;
              o_bad_addr   <= target_p0;
              o_flush      <= 1'b1;
            end else if (mispredict_p0) begin
              state              <= REDIRECT;
              o_ready            <= 1'b0;
              o_redirect_valid   <= 1'b1;
              o_redirect_pc      <= actual_p0;
              o_flush            <= 1'b1;
              o_mispredict_count <= o_mispredict_count + CNT_ONE;
            end
          end
        end
        REDIRECT: begin
          if (i_redirect_ready) begin
            state            <= IDLE;
            o_ready          <= 1'b1;
            o_redirect_valid <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          o_ready          <= 1'b1;
          o_redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a next-PC reference model checked every
// cycle, plus literal expectations for each scenario and a narrow-counter instance.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  op;
  logic        cond;
  logic        pred;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        rr;

  logic        ready, link_valid, redirect_valid, flush, misaligned;
  logic [31:0] link, redirect_pc, bad_addr, count;

  logic        ready2, link_valid2, redirect_valid2, flush2, misaligned2;
  logic [31:0] link2, redirect_pc2, bad_addr2;
  logic [1:0]  count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .CNT_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_op(op),
    .i_cond(cond), .i_pred_taken(pred), .i_pc(pc), .i_imm(imm), .i_rs1(rs1),
    .o_link_valid(link_valid), .o_link(link), .o_redirect_valid(redirect_valid),
    .i_redirect_ready(rr), .o_redirect_pc(redirect_pc), .o_flush(flush),
    .o_misaligned(misaligned), .o_bad_addr(bad_addr), .o_mispredict_count(count)
  );

  branch_resolve_unit #(.XLEN(32), .CNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready2), .i_op(op),
    .i_cond(cond), .i_pred_taken(pred), .i_pc(pc), .i_imm(imm), .i_rs1(rs1),
    .o_link_valid(link_valid2), .o_link(link2), .o_redirect_valid(redirect_valid2),
    .i_redirect_ready(rr), .o_redirect_pc(redirect_pc2), .o_flush(flush2),
    .o_misaligned(misaligned2), .o_bad_addr(bad_addr2), .o_mispredict_count(count2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next-PC rules evaluated on each accepted instruction.
  logic        m_rv, m_flush, m_mis, m_lv;
  logic [31:0] m_rpc, m_bad, m_link, m_cnt;
  logic        t_taken, t_bad;
  logic [31:0] t_tgt, t_next, t_pred;

  always @(posedge clk) begin
    if (rst) begin
      m_rv = 0; m_flush = 0; m_mis = 0; m_lv = 0;
      m_rpc = 0; m_bad = 0; m_link = 0; m_cnt = 0;
    end else begin
      m_flush = 0; m_mis = 0; m_lv = 0;
      if (m_rv) begin
        if (rr) m_rv = 0;
      end else if (valid) begin
        t_taken = (op == 2'd1) ? cond : (op >= 2'd2);
        t_tgt   = (op == 2'd3) ? ((rs1 + imm) & ~32'd1) : (pc + imm);
        t_next  = t_taken ? t_tgt : pc + 32'd4;
        if (op == 2'd1)      t_pred = pred ? pc + imm : pc + 32'd4;
        else if (op == 2'd2) t_pred = t_tgt;
        else                 t_pred = pc + 32'd4;
        t_bad = t_taken && (t_tgt % 4 != 0);
        if (op >= 2'd2) begin m_lv = 1; m_link = pc + 32'd4; end
        if (t_bad) begin
          m_mis = 1; m_bad = t_tgt; m_flush = 1;
        end else if (t_next != t_pred) begin
          m_rv = 1; m_rpc = t_next; m_flush = 1; m_cnt = m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ready", ready, !m_rv);
    chk("m_redirect_valid", redirect_valid, m_rv);
    chk("m_redirect_pc", redirect_pc, m_rpc);
    chk("m_flush", flush, m_flush);
    chk("m_misaligned", misaligned, m_mis);
    chk("m_bad_addr", bad_addr, m_bad);
    chk("m_link_valid", link_valid, m_lv);
    chk("m_link", link, m_link);
    chk("m_count", count, m_cnt);
    chk("m_count2", count2, m_cnt % 4);
    chk("m_redirect_valid2", redirect_valid2, m_rv);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] o, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] r, input logic c, input logic pt);
    valid = 1; op = o; pc = p; imm = i; rs1 = r; cond = c; pred = pt;
  endtask

  initial begin
    rst = 1; valid = 0; op = 0; cond = 0; pred = 0; pc = 0; imm = 0; rs1 = 0; rr = 0;
    cyc(); cyc();
    chk("reset_ready", ready, 1);
    chk("reset_count", count, 0);
    chk("reset_redirect_valid", redirect_valid, 0);
    chk("reset_link", link, 0);
    rst = 0;

    // Taken mispredict
    rr = 1;
    drive(2'd1, 32'h100, 32'h20, 32'h0, 1, 0);
    cyc(); valid = 0;
    chk("tm_redirect_valid", redirect_valid, 1);
    chk("tm_redirect_pc", redirect_pc, 32'h120);
    chk("tm_flush", flush, 1);
    chk("tm_count", count, 1);
    chk("tm_ready_busy", ready, 0);
    cyc();
    chk("tm_ready_back", ready, 1);
    chk("tm_flush_gone", flush, 0);

    // Correct predictions back to back
    for (int k = 0; k < 4; k++) begin
      drive(2'd1, 32'h400 + 32'(k * 4), 32'h80, 32'h0, 0, 0);
      cyc();
      chk("cp_ready", ready, 1);
      chk("cp_redirect", redirect_valid, 0);
      chk("cp_flush", flush, 0);
      chk("cp_count", count, 1);
    end
    valid = 0;

    // JALR: base+offset with bit 0 cleared
    drive(2'd3, 32'h100, 32'h4, 32'h2001, 0, 0);
    cyc(); valid = 0;
    chk("jalr_redirect_pc", redirect_pc, 32'h2004);
    chk("jalr_link_valid", link_valid, 1);
    chk("jalr_link", link, 32'h104);
    chk("jalr_count", count, 2);
    cyc();
    chk("jalr_link_pulse", link_valid, 0);

    // Backpressure: predicted taken, actually not taken
    rr = 0;
    drive(2'd1, 32'h200, 32'h40, 32'h0, 0, 1);
    cyc();
    chk("bp_redirect_pc", redirect_pc, 32'h204);
    chk("bp_flush_first", flush, 1);
    drive(2'd1, 32'h500, 32'h10, 32'h0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold_valid", redirect_valid, 1);
      chk("bp_hold_pc", redirect_pc, 32'h204);
      chk("bp_ready_low", ready, 0);
      chk("bp_no_flush", flush, 0);
      chk("bp_count", count, 3);
    end
    valid = 0; rr = 1;
    cyc();
    chk("bp_release_valid", redirect_valid, 0);
    chk("bp_release_ready", ready, 1);

    // Misaligned JAL target
    drive(2'd2, 32'h100, 32'h6, 32'h0, 0, 0);
    cyc(); valid = 0;
    chk("mis_pulse", misaligned, 1);
    chk("mis_bad_addr", bad_addr, 32'h106);
    chk("mis_flush", flush, 1);
    chk("mis_link", link, 32'h104);
    chk("mis_no_redirect", redirect_valid, 0);
    chk("mis_count", count, 3);
    cyc();
    chk("mis_pulse_end", misaligned, 0);

    // Not-taken branch with odd offset is neither misaligned nor mispredicted
    drive(2'd1, 32'h300, 32'h2, 32'h0, 0, 0);
    cyc(); valid = 0;
    chk("nt_odd_mis", misaligned, 0);
    chk("nt_odd_redirect", redirect_valid, 0);

    // Address wrap: JAL wraps and matches its prediction; branch wraps and mispredicts
    drive(2'd2, 32'hFFFF_FFFC, 32'h8, 32'h0, 0, 0);
    cyc();
    chk("wrap_jal_redirect", redirect_valid, 0);
    chk("wrap_jal_link", link, 32'h0);
    drive(2'd1, 32'hFFFF_FFF0, 32'h20, 32'h0, 1, 0);
    cyc(); valid = 0;
    chk("wrap_br_pc", redirect_pc, 32'h10);
    chk("wrap_br_count", count, 4);
    cyc();

    // Reset while a redirect is pending
    rr = 0;
    drive(2'd3, 32'h100, 32'h0, 32'h800, 0, 0);
    cyc(); valid = 0;
    chk("rst_pre_valid", redirect_valid, 1);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_ready", ready, 1);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_link", link, 0);
    chk("rst_bad_addr", bad_addr, 0);
    chk("rst_count", count, 0);

    // Five mispredicts: the 2-bit counter wraps to 1
    rr = 1;
    for (int k = 0; k < 5; k++) begin
      drive(2'd1, 32'h1000 + 32'(k * 16), 32'h40, 32'h0, 1, 0);
      cyc(); valid = 0;
      cyc();
    end
    chk("wrap_count2", count2, 2'd1);
    chk("wrap_count32", count, 5);

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
